// File: rtl/alu_cmd_sequencer.sv
// Drives the tiny ALU from a valid/ready command port and returns results on a
// valid/ready response port, enforcing the post-op drain gap and a done timeout.
module alu_cmd_sequencer #(
   parameter int TIMEOUT    = 15,
   parameter int GAP_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   input  logic [2:0]  cmd_op,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_result,
   output logic [2:0]  rsp_op,
   output logic        rsp_timeout,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [2:0]  alu_op,
   output logic        alu_start,
   input  logic        alu_done,
   input  logic [15:0] alu_result,
   output logic        busy
);

   localparam int TW = $clog2(TIMEOUT);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t        r_state,       w_state_nxt;
   logic [7:0]    r_alu_a,       w_alu_a_nxt;
   logic [7:0]    r_alu_b,       w_alu_b_nxt;
   logic [2:0]    r_alu_op,      w_alu_op_nxt;
   logic          r_alu_start,   w_alu_start_nxt;
   logic          r_rsp_valid,   w_rsp_valid_nxt;
   logic [15:0]   r_rsp_result,  w_rsp_result_nxt;
   logic [2:0]    r_rsp_op,      w_rsp_op_nxt;
   logic          r_rsp_timeout, w_rsp_timeout_nxt;
   logic [TW-1:0] r_tmo_cnt,     w_tmo_cnt_nxt;
   logic [GW-1:0] r_gap_cnt,     w_gap_cnt_nxt;
   logic          r_busy;
   logic          w_cmd_ready;

   assign w_cmd_ready = (r_state == S_IDLE) && (r_gap_cnt == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_alu_a       <= '0;
         r_alu_b       <= '0;
         r_alu_op      <= '0;
         r_alu_start   <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_result  <= '0;
         r_rsp_op      <= '0;
         r_rsp_timeout <= 1'b0;
         r_tmo_cnt     <= '0;
         r_gap_cnt     <= '0;
         r_busy        <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_alu_a       <= w_alu_a_nxt;
         r_alu_b       <= w_alu_b_nxt;
         r_alu_op      <= w_alu_op_nxt;
         r_alu_start   <= w_alu_start_nxt;
         r_rsp_valid   <= w_rsp_valid_nxt;
         r_rsp_result  <= w_rsp_result_nxt;
         r_rsp_op      <= w_rsp_op_nxt;
         r_rsp_timeout <= w_rsp_timeout_nxt;
         r_tmo_cnt     <= w_tmo_cnt_nxt;
         r_gap_cnt     <= w_gap_cnt_nxt;
         r_busy        <= (w_state_nxt != S_IDLE) || (w_gap_cnt_nxt != '0);
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_alu_a_nxt       = r_alu_a;
      w_alu_b_nxt       = r_alu_b;
      w_alu_op_nxt      = r_alu_op;
      w_alu_start_nxt   = r_alu_start;
      w_rsp_valid_nxt   = r_rsp_valid;
      w_rsp_result_nxt  = r_rsp_result;
      w_rsp_op_nxt      = r_rsp_op;
      w_rsp_timeout_nxt = r_rsp_timeout;
      w_tmo_cnt_nxt     = r_tmo_cnt;
      w_gap_cnt_nxt     = (r_gap_cnt != '0) ? r_gap_cnt - GW'(1) : r_gap_cnt;

      case (r_state)
         S_IDLE: begin
            if (cmd_valid && w_cmd_ready) begin
               w_alu_a_nxt  = cmd_a;
               w_alu_b_nxt  = cmd_b;
               w_alu_op_nxt = cmd_op;
               w_rsp_op_nxt = cmd_op;
               if (cmd_op != 3'b000) begin
                  w_state_nxt     = S_WAIT;
                  w_alu_start_nxt = 1'b1;
                  w_tmo_cnt_nxt   = '0;
               end else begin
                  w_state_nxt       = S_RESP;
                  w_rsp_valid_nxt   = 1'b1;
                  w_rsp_result_nxt  = '0;
                  w_rsp_timeout_nxt = 1'b0;
               end
            end
         end
         S_WAIT: begin
            // done on the final timeout cycle is still a normal completion
            if (alu_done) begin
               w_rsp_result_nxt  = alu_result;
               w_rsp_timeout_nxt = 1'b0;
               w_alu_start_nxt   = 1'b0;
               w_gap_cnt_nxt     = GAP_LOAD;
               w_rsp_valid_nxt   = 1'b1;
               w_state_nxt       = S_RESP;
            end else if (r_tmo_cnt == TMO_LAST) begin
               w_rsp_result_nxt  = '0;
               w_rsp_timeout_nxt = 1'b1;
               w_alu_start_nxt   = 1'b0;
               w_gap_cnt_nxt     = GAP_LOAD;
               w_rsp_valid_nxt   = 1'b1;
               w_state_nxt       = S_RESP;
            end else begin
               w_tmo_cnt_nxt = r_tmo_cnt + TW'(1);
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               w_rsp_valid_nxt = 1'b0;
               w_state_nxt     = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign cmd_ready   = w_cmd_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_result  = r_rsp_result;
   assign rsp_op      = r_rsp_op;
   assign rsp_timeout = r_rsp_timeout;
   assign alu_a       = r_alu_a;
   assign alu_b       = r_alu_b;
   assign alu_op      = r_alu_op;
   assign alu_start   = r_alu_start;
   assign busy        = r_busy;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU stub
// (1-cycle add/and/xor, 4-cycle mul, optional dead mode with done never raised).
module tb_alu_cmd_sequencer;

   logic        clk;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_a;
   logic [7:0]  cmd_b;
   logic [2:0]  cmd_op;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_result;
   logic [2:0]  rsp_op;
   logic        rsp_timeout;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [2:0]  alu_op;
   logic        alu_start;
   logic        alu_done;
   logic [15:0] alu_result;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   alu_cmd_sequencer #(.TIMEOUT(15), .GAP_CYCLES(4)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_a       (cmd_a),
      .cmd_b       (cmd_b),
      .cmd_op      (cmd_op),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_result  (rsp_result),
      .rsp_op      (rsp_op),
      .rsp_timeout (rsp_timeout),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_op      (alu_op),
      .alu_start   (alu_start),
      .alu_done    (alu_done),
      .alu_result  (alu_result),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU stub
   logic       alu_dead;
   logic       stub_busy;
   logic [1:0] stub_cnt;

   function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
      if (op[2])             return 16'(a) * 16'(b);
      else if (op == 3'b001) return 16'(a) + 16'(b);
      else if (op == 3'b010) return 16'(a & b);
      else if (op == 3'b011) return 16'(a ^ b);
      else                   return 16'h0000;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stub_busy  <= 1'b0;
         stub_cnt   <= 2'd0;
         alu_done   <= 1'b0;
         alu_result <= 16'h0000;
      end else begin
         alu_done <= 1'b0;
         if (!stub_busy) begin
            if (alu_start) begin
               stub_busy <= 1'b1;
               stub_cnt  <= alu_op[2] ? 2'd3 : 2'd0;
               if (!alu_op[2]) begin
                  alu_done   <= !alu_dead;
                  alu_result <= alu_fn(alu_a, alu_b, alu_op);
               end
            end
         end else if (stub_cnt != 2'd0) begin
            stub_cnt <= stub_cnt - 2'd1;
            if (stub_cnt == 2'd1) begin
               alu_done   <= !alu_dead;
               alu_result <= alu_fn(alu_a, alu_b, alu_op);
            end
         end else if (!alu_start) begin
            stub_busy <= 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Waits (bounded) for cmd_ready, handshakes one command, returns at handshake+1.
   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      int n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("send_ready", {31'd0, cmd_ready}, 32'd1);
      cmd_a     = a;
      cmd_b     = b;
      cmd_op    = op;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Called at handshake+1; lat ends as the cycle offset where rsp_valid is seen.
   task automatic wait_rsp(input int max, output int lat);
      lat = 1;
      while (!rsp_valid && lat < max) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int n_hi;
      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_a     = '0;
      cmd_b     = '0;
      cmd_op    = '0;
      rsp_ready = 1'b1;
      alu_dead  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_start",  {31'd0, alu_start}, 32'd0);
      check("rst_rvalid", {31'd0, rsp_valid}, 32'd0);
      check("rst_result", {16'd0, rsp_result}, 32'd0);
      check("rst_busy",   {31'd0, busy}, 32'd0);
      check("rst_alu_a",  {24'd0, alu_a}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("idle_ready", {31'd0, cmd_ready}, 32'd1);

      // add 12+34: start t+1, rsp t+3, gap releases cmd_ready at t+7
      send(8'h12, 8'h34, 3'b001);
      check("add_start1", {31'd0, alu_start}, 32'd1);
      check("add_alu_a",  {24'd0, alu_a}, 32'h12);
      check("add_alu_b",  {24'd0, alu_b}, 32'h34);
      check("add_nordy",  {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
      check("add_start2", {31'd0, alu_start}, 32'd1);
      check("add_rv2",    {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      check("add_rv3",    {31'd0, rsp_valid}, 32'd1);
      check("add_res",    {16'd0, rsp_result}, 32'h0046);
      check("add_tmo",    {31'd0, rsp_timeout}, 32'd0);
      check("add_rop",    {29'd0, rsp_op}, 32'd1);
      check("add_start3", {31'd0, alu_start}, 32'd0);
      @(negedge clk);
      check("add_rv4",    {31'd0, rsp_valid}, 32'd0);
      check("add_gap4",   {31'd0, cmd_ready}, 32'd0);
      repeat (2) @(negedge clk);
      check("add_gap6",   {31'd0, cmd_ready}, 32'd0);
      check("add_busy6",  {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("add_rdy7",   {31'd0, cmd_ready}, 32'd1);
      check("add_busy7",  {31'd0, busy}, 32'd0);

      // mul FF*FF: start held t+1..t+5, rsp t+6
      send(8'hFF, 8'hFF, 3'b100);
      for (int i = 1; i <= 5; i++) begin
         check($sformatf("mul_start%0d", i), {31'd0, alu_start}, 32'd1);
         check($sformatf("mul_rv%0d", i),    {31'd0, rsp_valid}, 32'd0);
         @(negedge clk);
      end
      check("mul_rv6",    {31'd0, rsp_valid}, 32'd1);
      check("mul_res",    {16'd0, rsp_result}, 32'hFE01);
      check("mul_start6", {31'd0, alu_start}, 32'd0);

      // no_op: rsp at t+1, no ALU activity, no gap
      send(8'h55, 8'h66, 3'b000);
      check("nop_rv1",    {31'd0, rsp_valid}, 32'd1);
      check("nop_res",    {16'd0, rsp_result}, 32'd0);
      check("nop_rop",    {29'd0, rsp_op}, 32'd0);
      check("nop_start1", {31'd0, alu_start}, 32'd0);
      @(negedge clk);
      check("nop_start2", {31'd0, alu_start}, 32'd0);
      check("nop_rdy2",   {31'd0, cmd_ready}, 32'd1);

      // xor then and, cmd_valid held, first response stalled 5 cycles
      rsp_ready = 1'b0;
      cmd_a     = 8'hF0;
      cmd_b     = 8'h3C;
      cmd_op    = 3'b011;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_op = 3'b010;
      check("xa_rdy1", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
      check("xa_rdy2", {31'd0, cmd_ready}, 32'd0);
      check("xa_rv2",  {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("xa_hold_rv%0d", i),  {31'd0, rsp_valid}, 32'd1);
         check($sformatf("xa_hold_res%0d", i), {16'd0, rsp_result}, 32'h00CC);
         check($sformatf("xa_hold_rdy%0d", i), {31'd0, cmd_ready}, 32'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      check("xa_rop1", {29'd0, rsp_op}, 32'd3);
      check("xa_res1", {16'd0, rsp_result}, 32'h00CC);
      @(negedge clk);
      check("xa_rv9",  {31'd0, rsp_valid}, 32'd0);
      check("xa_rdy9", {31'd0, cmd_ready}, 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("and_start", {31'd0, alu_start}, 32'd1);
      check("and_aluop", {29'd0, alu_op}, 32'd2);
      wait_rsp(20, lat);
      check("and_lat", lat, 32'd3);
      check("and_res", {16'd0, rsp_result}, 32'h0030);
      check("and_rop", {29'd0, rsp_op}, 32'd2);

      // dead ALU: start high exactly TIMEOUT cycles, then timeout response
      alu_dead = 1'b1;
      send(8'h01, 8'h02, 3'b001);
      n_hi = 0;
      while (alu_start && n_hi < 40) begin
         n_hi++;
         @(negedge clk);
      end
      check("tmo_cycles", n_hi, 32'd15);
      check("tmo_rv",     {31'd0, rsp_valid}, 32'd1);
      check("tmo_flag",   {31'd0, rsp_timeout}, 32'd1);
      check("tmo_res",    {16'd0, rsp_result}, 32'd0);
      alu_dead = 1'b0;
      @(negedge clk);

      // reset during mul WAIT
      send(8'h03, 8'h04, 3'b100);
      @(negedge clk);
      check("rw_start_pre", {31'd0, alu_start}, 32'd1);
      reset_n = 1'b0;
      #1;
      check("rw_start", {31'd0, alu_start}, 32'd0);
      check("rw_rv",    {31'd0, rsp_valid}, 32'd0);
      check("rw_busy",  {31'd0, busy}, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("rw_rdy",  {31'd0, cmd_ready}, 32'd1);
      check("rw_rv2",  {31'd0, rsp_valid}, 32'd0);
      send(8'h01, 8'h01, 3'b001);
      wait_rsp(20, lat);
      check("rw_lat", lat, 32'd3);
      check("rw_res", {16'd0, rsp_result}, 32'h0002);
      check("rw_tmo", {31'd0, rsp_timeout}, 32'd0);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
